mod_exp_engine: RTL and testbench
=================================

Name: mod_exp_engine

Overview:
- Parametrised modular exponentiation engine: result = M^e mod n for W-bit operands.
- Left-to-right binary square-and-multiply over a bit-serial interleaved (Blakley) modular multiplier. Each step is a shift, add and conditional subtract; no wide multiplier and no divider.
- Sits in the serverside RSA datapath as the successor to the fixed 16-bit repeated-multiply block.
- Supports any exponent, including e=0, and any base, including M>=n.

Parameters:
- W, 16, operand width of M, e, n and result.
- CW, 5, step counter width; must satisfy 2^CW > W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- M  in  W  base; latched on accepted start.
- e  in  W  exponent; latched on accepted start.
- n  in  W  modulus; latched on accepted start.
- busy  out  1  high from the cycle after accepted start until finished.
- finished  out  1  one-cycle pulse when result/err are valid.
- err  out  1  modulus invalid (n<2); held until next accepted start.
- result  out  W  M^e mod n; held until next accepted start.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, finished=0, err=0, result=0; all internal registers cleared.
- Reset mid-operation aborts immediately. No finished pulse is produced.
- States: IDLE, REDUCE, SQUARE, MULT, DONE.
- IDLE:
  - start=1 latches M, e, n, clears err, and sets busy.
  - If n<2: next state DONE with err=1, result=0.
  - Otherwise: next state REDUCE.
  - start while busy is ignored; operands cannot change mid-operation.
- Modular multiply step (shared by all compute states):
  - Computes acc = a*b mod n, scanning b from MSB to LSB, one bit per cycle, W cycles in total.
  - acc starts at 0.
  - Each cycle: t = 2*acc; if t>=n then t = t-n; if b[i] then t = t+a; if t>=n then t = t-n; acc = t.
  - Internal width is W+2 bits so no intermediate overflows.
  - Precondition: a<n and acc<n, so acc stays < n throughout.
- REDUCE: a=1, b=M. Produces base = M mod n in W cycles. Valid for M>=n. R is set to 1.
- Exponent scan: bit index j runs from W-1 down to 0. Leading zero bits are not skipped, so latency is fixed per popcount.
- SQUARE: a=R, b=R, W cycles, R = R*R mod n. Then:
  - if e[j]=1, go to MULT;
  - else if j=0, go to DONE;
  - else decrement j and stay in SQUARE.
- MULT: a=base, b=R, W cycles, R = R*base mod n. Then go to DONE if j=0, else decrement j and go to SQUARE.
- DONE:
  - result = R (or 0 on err).
  - finished=1 for exactly one cycle, busy=0; next state IDLE.
  - start asserted during DONE is ignored; start is accepted from IDLE only.
- e=0 gives result = 1 mod n = 1 (n>=2).
- M=0 with e>0 gives 0. M=0 with e=0 gives 1.
- Latency from the accepting edge to the finished pulse: L = W*(1 + W + popcount(e)) + 1 cycles. For err, L = 1.

Optional Feature:
- Macro: MOD_EXP_CONST_TIME_EN.
- When defined:
  - MULT is entered for every exponent bit.
  - When e[j]=0, the product is computed but R is not updated.
  - L = W*(1 + 2W) + 1, independent of e. This removes the timing side channel on the private exponent.
- When undefined: the behaviour above, with MULT only for set bits.

Test Plan:
- W=16, M=65, e=17, n=3233, start pulse -> result=2790, err=0, finished exactly 305 cycles after the accepting edge, busy high for that interval.
- W=16, M=2790, e=2753, n=3233 -> result=65 (RSA decrypt round trip).
- M=4000, e=1, n=3233 -> result=767 (base >= n is reduced). Then M=9, e=0, n=3233 -> result=1.
- n=1 (and n=0), any M/e -> err=1, result=0, finished one cycle after start. Then a following valid start clears err.
- Start computation (65, 17, 3233); assert reset at cycle 100 -> all outputs 0 the same cycle, no finished pulse. Re-issue start -> 2790 with full latency. Start pulses while busy do not disturb the result.
- With MOD_EXP_CONST_TIME_EN defined: e=17 and e=2753 (n=3233) both finish in 529 cycles with correct results 2790 and 65.

Source files
------------

// File: rtl/mod_exp_if.sv
// mod_exp_if: request/response bundle of the modular exponentiation engine.
// The requester drives start and the operands; the engine drives status and result.
interface mod_exp_if #(
   parameter int W = 16
);
   logic          start;
   logic [W-1:0]  M;
   logic [W-1:0]  e;
   logic [W-1:0]  n;
   logic          busy;
   logic          finished;
   logic          err;
   logic [W-1:0]  result;

   modport master (
      output start, M, e, n,
      input  busy, finished, err, result
   );

   modport slave (
      input  start, M, e, n,
      output busy, finished, err, result
   );
endinterface

// File: rtl/mod_exp_engine.sv
// mod_exp_engine: result = M^e mod n, left-to-right binary square-and-multiply
// built on a bit-serial interleaved (Blakley) modular multiplier.
// Each multiplier cycle is a shift, an add and two conditional subtracts.
// Optional feature: define MOD_EXP_CONST_TIME_EN to run MULT for every
// exponent bit (discarding the product on zero bits), making latency
// independent of the exponent.
module mod_exp_engine #(
   parameter int W  = 16,
   parameter int CW = 5
) (
   input  logic   clk,
   input  logic   reset,
   mod_exp_if.slave bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_REDUCE = 3'd1;
   localparam logic [2:0] S_SQUARE = 3'd2;
   localparam logic [2:0] S_MULT   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   // One interleaved multiply step: acc' = (2*acc + bit*a) mod n, with acc, a < n.
   // Two extra bits of headroom keep 2*acc + a from overflowing.
   function automatic logic [W-1:0] modmul_step(
      input logic [W-1:0] acc,
      input logic [W-1:0] a,
      input logic         b_bit,
      input logic [W-1:0] modulus
   );
      logic [W+1:0] t;
      logic [W+1:0] nn;
      nn = {2'b00, modulus};
      t  = {1'b0, acc, 1'b0};
      if (t >= nn) t = t - nn;
      if (b_bit)   t = t + {2'b00, a};
      if (t >= nn) t = t - nn;
      return t[W-1:0];
   endfunction

   logic [2:0]    state_q,    state_d;
   logic [W-1:0]  m_q,        m_d;
   logic [W-1:0]  e_q,        e_d;
   logic [W-1:0]  n_q,        n_d;
   logic [W-1:0]  base_q,     base_d;
   logic [W-1:0]  r_q,        r_d;
   logic [W-1:0]  acc_q,      acc_d;
   logic [CW-1:0] cnt_q,      cnt_d;
   logic [CW-1:0] j_q,        j_d;
   logic          busy_q,     busy_d;
   logic          finished_q, finished_d;
   logic          err_q,      err_d;
   logic [W-1:0]  result_q,   result_d;

   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic [W-1:0]  b_shift;
   logic [W-1:0]  e_shift;
   logic [W-1:0]  step;
   logic          last_step;
   logic          e_bit;

   // Multiplier operand selection: the operands stay constant for a whole
   // multiply because R and base only change on its final cycle.
   always_comb begin
      op_a = '0;
      op_b = '0;
      case (state_q)
         S_REDUCE: begin op_a = W'(1); op_b = m_q; end
         S_SQUARE: begin op_a = r_q;   op_b = r_q; end
         S_MULT:   begin op_a = base_q; op_b = r_q; end
         default:  begin op_a = '0;    op_b = '0;  end
      endcase
      b_shift   = op_b >> cnt_q;
      e_shift   = e_q >> j_q;
      e_bit     = e_shift[0];
      last_step = (cnt_q == '0);
      step      = modmul_step(acc_q, op_a, b_shift[0], n_q);
   end

   // Next-state logic for the control FSM and the exponentiation datapath.
   always_comb begin
      state_d    = state_q;
      m_d        = m_q;
      e_d        = e_q;
      n_d        = n_q;
      base_d     = base_q;
      r_d        = r_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      j_d        = j_q;
      busy_d     = busy_q;
      finished_d = 1'b0;
      err_d      = err_q;
      result_d   = result_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               m_d    = bus.M;
               e_d    = bus.e;
               n_d    = bus.n;
               r_d    = W'(1);
               acc_d  = '0;
               cnt_d  = CW'(W - 1);
               j_d    = CW'(W - 1);
               busy_d = 1'b1;
               if (bus.n < W'(2)) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b0;
                  state_d = S_REDUCE;
               end
            end
         end

         S_REDUCE, S_SQUARE, S_MULT: begin
            acc_d = step;
            cnt_d = cnt_q - 1'b1;
            if (last_step) begin
               // Multiply finished: restart the accumulator for the next one.
               acc_d = '0;
               cnt_d = CW'(W - 1);
               case (state_q)
                  S_REDUCE: begin
                     base_d  = step;
                     r_d     = W'(1);
                     state_d = S_SQUARE;
                  end
                  S_SQUARE: begin
                     r_d = step;
`ifdef MOD_EXP_CONST_TIME_EN
                     state_d = S_MULT;
`else
                     if (e_bit) begin
                        state_d = S_MULT;
                     end else if (j_q == '0) begin
                        state_d = S_DONE;
                     end else begin
                        j_d = j_q - 1'b1;
                     end
`endif
                  end
                  default: begin
`ifdef MOD_EXP_CONST_TIME_EN
                     // Product is always computed; kept only for set exponent bits.
                     if (e_bit) r_d = step;
`else
                     r_d = step;
`endif
                     if (j_q == '0) begin
                        state_d = S_DONE;
                     end else begin
                        j_d     = j_q - 1'b1;
                        state_d = S_SQUARE;
                     end
                  end
               endcase
            end
         end

         S_DONE: begin
            result_d   = err_q ? '0 : r_q;
            finished_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers; reset aborts any operation immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         m_q        <= '0;
         e_q        <= '0;
         n_q        <= '0;
         base_q     <= '0;
         r_q        <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         j_q        <= '0;
         busy_q     <= 1'b0;
         finished_q <= 1'b0;
         err_q      <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         m_q        <= m_d;
         e_q        <= e_d;
         n_q        <= n_d;
         base_q     <= base_d;
         r_q        <= r_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         j_q        <= j_d;
         busy_q     <= busy_d;
         finished_q <= finished_d;
         err_q      <= err_d;
         result_q   <= result_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.finished = finished_q;
   assign bus.err      = err_q;
   assign bus.result   = result_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// tb_mod_exp_engine: directed vectors with hand-computed results for
// mod_exp_engine (W=16). Honours MOD_EXP_CONST_TIME_EN for expected latency.
module tb_mod_exp_engine;
   localparam int W = 16;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mod_exp_if #(.W(W)) bus ();

   mod_exp_engine #(.W(W), .CW(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Expected accept-to-finished latency for an exponent of the given popcount.
   function automatic int lat_of(input int pc);
`ifdef MOD_EXP_CONST_TIME_EN
      return W * (1 + 2 * W) + 1;
`else
      return W * (1 + W + pc) + 1;
`endif
   endfunction

   task automatic run_op(input logic [15:0] m, input logic [15:0] ex, input logic [15:0] nn,
                         input logic [15:0] exp_res, input logic exp_err, input int exp_lat,
                         input bit disturb, input string tag);
      int lat;
      bit busy_ok;
      @(negedge clk);
      bus.start = 1'b1;
      bus.M     = m;
      bus.e     = ex;
      bus.n     = nn;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat     = 0;
      busy_ok = 1'b1;
      while (!bus.finished && lat < 2000) begin
         if (!bus.busy) busy_ok = 1'b0;
         if (disturb && (lat == 50 || lat == exp_lat - 1)) begin
            bus.start = 1'b1;
            bus.M     = 16'd9;
            bus.e     = 16'd0;
            bus.n     = 16'd1;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      bus.start = 1'b0;
      chk({tag, "_lat"},    lat,         exp_lat);
      chk({tag, "_result"}, bus.result,  exp_res);
      chk({tag, "_err"},    bus.err,     exp_err);
      chk({tag, "_busy"},   busy_ok,     1);
      chk({tag, "_busy_at_fin"}, bus.busy, 0);
      @(posedge clk);
      #1;
      chk({tag, "_fin_pulse"}, bus.finished, 0);
      chk({tag, "_idle"},      bus.busy,     0);
      chk({tag, "_hold"},      bus.result,   exp_res);
      chk({tag, "_err_hold"},  bus.err,      exp_err);
   endtask

   initial begin
      int fin;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.M     = '0;
      bus.e     = '0;
      bus.n     = '0;
      #1;
      chk("rst_busy",     bus.busy,     0);
      chk("rst_finished", bus.finished, 0);
      chk("rst_err",      bus.err,      0);
      chk("rst_result",   bus.result,   0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      run_op(16'd65,   16'd17,   16'd3233, 16'd2790, 1'b0, lat_of(2), 1'b1, "rsa_enc");
      run_op(16'd2790, 16'd2753, 16'd3233, 16'd65,   1'b0, lat_of(5), 1'b0, "rsa_dec");
      run_op(16'd4000, 16'd1,    16'd3233, 16'd767,  1'b0, lat_of(1), 1'b0, "base_big");
      run_op(16'd9,    16'd0,    16'd3233, 16'd1,    1'b0, lat_of(0), 1'b0, "exp0");
      run_op(16'd0,    16'd5,    16'd3233, 16'd0,    1'b0, lat_of(2), 1'b0, "m0");
      run_op(16'd0,    16'd0,    16'd3233, 16'd1,    1'b0, lat_of(0), 1'b0, "m0_e0");
      run_op(16'd3,    16'd3,    16'd2,    16'd1,    1'b0, lat_of(2), 1'b0, "n2");
      run_op(16'd123,  16'd45,   16'd1,    16'd0,    1'b1, 1,         1'b0, "n1");
      run_op(16'd7,    16'd3,    16'd0,    16'd0,    1'b1, 1,         1'b0, "n0");
      run_op(16'd65,   16'd17,   16'd3233, 16'd2790, 1'b0, lat_of(2), 1'b0, "clr_err");

      // Abort an operation with reset around cycle 100.
      @(negedge clk);
      bus.start = 1'b1;
      bus.M     = 16'd65;
      bus.e     = 16'd17;
      bus.n     = 16'd3233;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (99) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_busy",     bus.busy,     0);
      chk("abort_finished", bus.finished, 0);
      chk("abort_err",      bus.err,      0);
      chk("abort_result",   bus.result,   0);
      fin = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (bus.finished) fin++;
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (400) begin
         @(posedge clk);
         #1;
         if (bus.finished) fin++;
      end
      chk("abort_no_finish", fin, 0);
      chk("abort_idle_busy", bus.busy, 0);

      run_op(16'd65,   16'd17,   16'd3233, 16'd2790, 1'b0, lat_of(2), 1'b1, "after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
